// File: rtl/axi_uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents: FSM state encoding, default character width, frame-length
// constants and a helper that returns the length of one frame in bit periods.
package axi_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  localparam int unsigned DATA_SIZE_DEF  = 8;
  localparam int unsigned FRAME_START_BITS = 1;
  localparam int unsigned FRAME_MAX_STOP   = 2;

  // Bit periods in one frame: start + data + optional parity + 1 or 2 stop.
  function automatic int unsigned frame_bits(input int unsigned data_size,
                                             input logic parity_en,
                                             input logic two_stop);
    return FRAME_START_BITS + data_size + (parity_en ? 1 : 0) + (two_stop ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset, clears the count
//   load_i  - reload the count from div_i (bit boundary / frame start)
//   div_i   - divisor; a bit lasts div_i+1 cycles
//   tick_o  - high on the last cycle of a bit (count reads 0)
module uart_baud_counter #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= div_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_WIDTH'(1);
    end
  end

  assign tick_o = (r_cnt == '0);

endmodule

// File: rtl/axi_uart_tx_serializer.sv
// UART transmit serializer fed from a TX FIFO head.
// Ports:
//   clk_i, rst_i       - clock and synchronous active-high reset
//   baud_div_i         - bit period is baud_div_i+1 cycles (latched per frame)
//   parity_en_i        - insert parity bit after data (latched per frame)
//   parity_odd_i       - 1 odd / 0 even parity (latched per frame)
//   two_stop_i         - 1 = two stop bits (latched per frame)
//   fifo_load_i        - FIFO head valid
//   fifo_data_i        - FIFO head data
//   fifo_pull_o        - one-cycle pull strobe, only in IDLE
//   tx_o               - serial line, idle high, registered
//   busy_o             - frame in progress
//   done_o             - pulse in the last cycle of the final stop bit
module axi_uart_tx_serializer
  import axi_uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 two_stop_i,
  input  logic                 fifo_load_i,
  input  logic [DATA_SIZE-1:0] fifo_data_i,
  output logic                 fifo_pull_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  uart_tx_state_t       r_state;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_arm;
  logic [DATA_SIZE-1:0] r_shift;
  logic [DIV_WIDTH-1:0] r_div;
  logic [IDX_W-1:0]     r_bit;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_two_stop;
  logic                 r_stop2nd;

  logic                 w_tick;
  logic                 w_pull;
  logic                 w_last_stop;
  logic                 w_cnt_load;
  logic [DIV_WIDTH-1:0] w_cnt_div;

  // Pull is a decode of registered state so data and config are captured in
  // the same cycle the FIFO sees the strobe. r_arm is cleared by reset and
  // blocks the first cycle after release.
  assign w_pull      = (r_state == ST_IDLE) & fifo_load_i & r_arm & ~rst_i;
  assign w_last_stop = (r_state == ST_STOP) & w_tick & (~r_two_stop | r_stop2nd);
  assign w_cnt_load  = w_pull | ((r_state != ST_IDLE) & w_tick);
  assign w_cnt_div   = w_pull ? baud_div_i : r_div;

  uart_baud_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_cnt_load),
    .div_i  (w_cnt_div),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_arm      <= 1'b0;
      r_shift    <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2nd  <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pull) begin
            r_shift    <= fifo_data_i;
            r_div      <= baud_div_i;
            r_par_en   <= parity_en_i;
            r_par_bit  <= (^fifo_data_i) ^ parity_odd_i;
            r_two_stop <= two_stop_i;
            r_stop2nd  <= 1'b0;
            r_bit      <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit == IDX_W'(DATA_SIZE - 1)) begin
              if (r_par_en) begin
                r_tx    <= r_par_bit;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit   <= r_bit + IDX_W'(1);
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (w_last_stop) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_stop2nd <= 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_pull_o = w_pull;
  assign tx_o        = r_tx;
  assign busy_o      = r_busy;
  assign done_o      = w_last_stop & ~rst_i;

endmodule

// File: tb/tb_axi_uart_tx_serializer.sv
// Directed self-checking bench for axi_uart_tx_serializer.
module tb_axi_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        fifo_load;
  logic [7:0]  fifo_data;
  logic        fifo_pull;
  logic        tx;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       load_mask = 1'b1;

  always #5 clk = ~clk;

  assign fifo_load = (wr_ptr != rd_ptr) && load_mask;
  assign fifo_data = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (fifo_pull === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  axi_uart_tx_serializer #(
    .DATA_SIZE(8),
    .DIV_WIDTH(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .baud_div_i   (baud_div),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .two_stop_i   (two_stop),
    .fifo_load_i  (fifo_load),
    .fifo_data_i  (fifo_data),
    .fifo_pull_o  (fifo_pull),
    .tx_o         (tx),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
  endtask

  // Returns with the current cycle being the pull cycle (waited = cycles skipped).
  task automatic wait_pull(input string tag, input int limit, output int waited);
    #1;
    waited = 0;
    while (fifo_pull !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_pull_seen"}, 32'(fifo_pull), 32'd1);
  endtask

  // Called in the pull cycle; vec holds the expected line level per bit
  // period, LSB first. Ends in the cycle after the final stop bit.
  task automatic frame_check(input string tag, input logic [15:0] vec,
                             input int nbits, input int per);
    int n, bi, glitch, first_done, ndone, nbusy, npull;
    logic [15:0] obs;
    n = nbits * per;
    obs = '0;
    glitch = 0; first_done = -1; ndone = 0; nbusy = 0; npull = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      bi = (i - 1) / per;
      if (tx !== vec[bi]) glitch++;
      if ((i - 1) % per == per / 2) obs[bi] = tx;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = i;
      end
      if (busy === 1'b1) nbusy++;
      if (fifo_pull === 1'b1) npull++;
    end
    check_eq({tag, "_bits"},     32'(obs),        32'(vec));
    check_eq({tag, "_glitches"}, 32'(glitch),     32'd0);
    check_eq({tag, "_done_at"},  32'(first_done), 32'(n));
    check_eq({tag, "_done_cnt"}, 32'(ndone),      32'd1);
    check_eq({tag, "_busy_cnt"}, 32'(nbusy),      32'(n));
    check_eq({tag, "_pull_mid"}, 32'(npull),      32'd0);
    @(negedge clk);
    check_eq({tag, "_gap_tx"},   32'(tx),   32'd1);
    check_eq({tag, "_gap_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_gap_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, base, cnt_a, cnt_b, cnt_c;
    rst = 1'b1; baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx",   32'(tx),        32'd1);
    check_eq("rst_busy", 32'(busy),      32'd0);
    check_eq("rst_done", 32'(done),      32'd0);
    push(8'h55);
    #1;
    check_eq("rst_pull", 32'(fifo_pull), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_c1_pull", 32'(fifo_pull), 32'd0);

    // 0x55, div=3, no parity, one stop
    wait_pull("f55", 10, w);
    frame_check("f55", 16'h02AA, 10, 4);
    check_eq("f55_pulls", 32'(rd_ptr), 32'd1);

    // 0x07 even then odd parity, div=1
    baud_div = 16'd1; parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h07);
    wait_pull("peven", 10, w);
    frame_check("peven", 16'h060E, 11, 2);
    parity_odd = 1'b1;
    push(8'h07);
    wait_pull("podd", 10, w);
    frame_check("podd", 16'h040E, 11, 2);

    // three queued entries, div=0, two stop bits
    baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
    base = rd_ptr;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_pull("b2b0", 10, w);
    frame_check("b2b0", 16'h0600, 11, 1);
    wait_pull("b2b1", 0, w);
    check_eq("b2b1_gap_wait", 32'(w), 32'd0);
    frame_check("b2b1", 16'h07FE, 11, 1);
    wait_pull("b2b2", 0, w);
    check_eq("b2b2_gap_wait", 32'(w), 32'd0);
    frame_check("b2b2", 16'h0678, 11, 1);
    check_eq("b2b_no_extra_pull", 32'(fifo_pull), 32'd0);
    check_eq("b2b_pulls", 32'(rd_ptr - base), 32'd3);

    // reset during data bit 3 of 0xA3
    baud_div = 16'd3; two_stop = 1'b0;
    base = rd_ptr;
    push(8'hA3);
    wait_pull("rsta3", 10, w);
    repeat (17) @(negedge clk);
    push(8'h5A);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_tx",   32'(tx),        32'd1);
    check_eq("rstmid_busy", 32'(busy),      32'd0);
    check_eq("rstmid_done", 32'(done),      32'd0);
    check_eq("rstmid_pull", 32'(fifo_pull), 32'd0);
    cnt_a = 0;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1 || fifo_pull === 1'b1) cnt_a++;
    end
    check_eq("rstmid_quiet", 32'(cnt_a), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rstrel_c1_pull", 32'(fifo_pull), 32'd0);
    wait_pull("rstnext", 10, w);
    check_eq("rstrel_no_early_pull", 32'(w >= 1), 32'd1);
    frame_check("rstnext", 16'h02B4, 10, 4);
    check_eq("rst_pulls", 32'(rd_ptr - base), 32'd2);

    // config and fifo_load changes mid-frame
    baud_div = 16'd3;
    push(8'h55); push(8'h0F);
    wait_pull("cfga", 10, w);
    fork
      begin
        repeat (10) @(negedge clk);
        baud_div = 16'd7;
        load_mask = 1'b0;
        repeat (10) @(negedge clk);
        load_mask = 1'b1;
      end
    join_none
    frame_check("cfga", 16'h02AA, 10, 4);
    wait_pull("cfgb", 0, w);
    frame_check("cfgb", 16'h021E, 10, 8);

    // empty FIFO for 100 cycles
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_pull === 1'b1) cnt_a++;
      if (tx !== 1'b1) cnt_b++;
      if (busy === 1'b1) cnt_c++;
    end
    check_eq("idle_pulls",  32'(cnt_a), 32'd0);
    check_eq("idle_tx_low", 32'(cnt_b), 32'd0);
    check_eq("idle_busy",   32'(cnt_c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_uart_tx_serializer.md
AXI_UART_TX_SERIALIZER -- requirements
Module: axi_uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, giving the character width in bits.
REQ-002 The block SHALL have parameter DIV_WIDTH, default 16, giving the baud divisor width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port baud_div_i, input, DIV_WIDTH bits: each bit lasts baud_div_i+1 clk_i cycles.
REQ-006 The block SHALL have port parity_en_i, input, 1 bit: 1 = parity bit inserted after the data bits.
REQ-007 The block SHALL have port parity_odd_i, input, 1 bit: 1 = odd parity, 0 = even parity.
REQ-008 The block SHALL have port two_stop_i, input, 1 bit: 1 = two stop bits, 0 = one stop bit.
REQ-009 The block SHALL have port fifo_load_i, input, 1 bit: TX FIFO head entry is valid (the FIFO "load" status bit).
REQ-010 The block SHALL have port fifo_data_i, input, DATA_SIZE bits: TX FIFO head data, combinational from the FIFO.
REQ-011 The block SHALL have port fifo_pull_o, output, 1 bit: single-cycle pull strobe to the TX FIFO.
REQ-012 The block SHALL have port tx_o, output, 1 bit: serial line, idle high.
REQ-013 The block SHALL have port busy_o, output, 1 bit: high while a frame is in progress.
REQ-014 The block SHALL have port done_o, output, 1 bit: single-cycle pulse on frame completion.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-016 In IDLE with fifo_load_i=1, the block SHALL assert fifo_pull_o for exactly one cycle, capture fifo_data_i, baud_div_i, parity_en_i, parity_odd_i and two_stop_i in that same cycle, and move to START.
REQ-017 fifo_pull_o SHALL never be asserted outside IDLE and never on two consecutive cycles.
REQ-018 tx_o SHALL be registered: 0 in START, the data bits LSB first in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-019 tx_o SHALL fall in the cycle after the pull cycle.
REQ-020 A bit counter SHALL reload to the latched divisor at each bit boundary and decrement to 0; a bit ends on the cycle the counter reads 0.
REQ-021 The bit index SHALL count 0..DATA_SIZE-1; DATA SHALL exit to PARITY if parity is enabled, otherwise to STOP.
REQ-022 The parity bit SHALL equal XOR(data) for even parity and ~XOR(data) for odd parity.
REQ-023 STOP SHALL last 1 or 2 bit periods according to the latched two_stop_i.
REQ-024 done_o SHALL pulse in the last cycle of STOP, and the FSM SHALL enter IDLE on the next cycle.
REQ-025 Back-to-back frames SHALL have exactly one idle-high clock between the final stop bit and the next start bit.
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 Changes on configuration inputs mid-frame SHALL NOT affect the current frame.
REQ-028 baud_div_i=0 SHALL give a one-cycle bit period.
REQ-029 fifo_load_i falling mid-frame SHALL have no effect on the current frame.

Reset
REQ-030 While rst_i=1, the block SHALL force the FSM to IDLE, tx_o=1, fifo_pull_o=0, busy_o=0, done_o=0, and clear the counters and the shift register.
REQ-031 An in-flight frame SHALL be abandoned on reset without a done_o pulse, and the FIFO entry already pulled for it is lost.
REQ-032 No pull SHALL occur in the first cycle after rst_i deasserts.

Structure
REQ-033 The state encoding, a DATA_SIZE default constant and frame-length constants SHALL live in a shared package, axi_uart_pkg.
REQ-034 The divisor counter SHALL be a sub-module, uart_baud_counter, with load/tick ports and DIV_WIDTH as its parameter.
REQ-035 The block SHALL have no asynchronous reset and no latches.

Verification
REQ-036 Byte 0x55 with div=3, no parity, one stop bit -> one pull; tx_o = 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit; done_o at cycle 40 after the pull.
REQ-037 Byte 0x07 with even parity and div=1 -> parity bit 1; the same byte with odd parity -> parity bit 0; frame length 22 cycles.
REQ-038 Three entries queued with div=0 and two stop bits -> three pulls, each frame 11 cycles, exactly one high gap cycle between frames.
REQ-039 rst_i asserted at data bit 3 of 0xA3 -> next cycle tx_o=1, busy_o=0, no done_o; after release, a pending entry is pulled no sooner than cycle 2.
REQ-040 baud_div_i changed from 3 to 7 mid-frame -> current frame stays at 4 cycles per bit; the next frame uses 8 cycles per bit.
REQ-041 fifo_load_i=0 for 100 cycles -> fifo_pull_o never asserted, tx_o constant 1.
